seq_alu_mc: RTL

- Parametrised, multi-cycle successor to the 32-bit combinational ALU.
- Keeps the existing opcode set: add, sub, mul, shift right/left, and, or, nor, slt.
- Adds unsigned divide/remainder, a full-width multiply high word, and a START/BUSY/DONE handshake; mul/div run iteratively over WIDTH cycles.
- Sits between the control unit and the register file; the control unit holds in its execute state until DONE.

---
 rtl/seq_alu_mc_pkg.sv | 23 ++
 rtl/seq_alu_mc_iter_muldiv.sv | 92 +++++++++
 rtl/seq_alu_mc.sv | 113 +++++++++++
 3 files changed

// File: rtl/seq_alu_mc_pkg.sv
// Shared opcode constants and FSM state type for the multi-cycle ALU.
package seq_alu_mc_pkg;

    localparam int unsigned ALU_OPRN_INDEX_LIMIT = 3;

    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_ADD  = 4'h1;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SUB  = 4'h2;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_MUL  = 4'h3;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SRL  = 4'h4;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SLL  = 4'h5;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_AND  = 4'h6;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_OR   = 4'h7;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_NOR  = 4'h8;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_SLT  = 4'h9;
    localparam logic [ALU_OPRN_INDEX_LIMIT:0] ALU_OPRN_DIVU = 4'hA;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StIter = 2'd2
    } alu_state_e;

endpackage

// File: rtl/seq_alu_mc_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// The first step is folded into the load so the result is ready WIDTH cycles after start.
module seq_alu_mc_iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             mode_i,   // 0: multiply, 1: divide
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

    logic [WIDTH-1:0] hi_q, lo_q, opd_q;
    logic             mode_q, run_q;
    logic [CntW-1:0]  cnt_q;

    logic             cur_mode;
    logic [WIDTH-1:0] cur_hi, cur_lo, cur_opd;
    logic [2*WIDTH-1:0] step_res;

    // hi:lo is the product accumulator (mul) or remainder:quotient shifter (div).
    function automatic logic [2*WIDTH-1:0] step(input logic div,
                                                 input logic [WIDTH-1:0] hi,
                                                 input logic [WIDTH-1:0] lo,
                                                 input logic [WIDTH-1:0] opd);
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   shifted;
        logic [WIDTH-1:0] rem;
        if (!div) begin
            sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
            step = {sum, lo[WIDTH-1:1]};
        end else begin
            shifted = {hi, lo[WIDTH-1]};
            rem     = shifted[WIDTH-1:0] - opd;
            if (shifted >= {1'b0, opd}) begin
                step = {rem, lo[WIDTH-2:0], 1'b1};
            end else begin
                step = {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
            end
        end
    endfunction

    always_comb begin
        cur_mode = mode_q;
        cur_hi   = hi_q;
        cur_lo   = lo_q;
        cur_opd  = opd_q;
        if (start_i) begin
            cur_mode = mode_i;
            cur_hi   = '0;
            cur_lo   = mode_i ? op_a_i : op_b_i;
            cur_opd  = mode_i ? op_b_i : op_a_i;
        end
        step_res = step(cur_mode, cur_hi, cur_lo, cur_opd);
    end

    assign done_o = run_q && (cnt_q == CntLast);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
            mode_q <= 1'b0;
            run_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            {hi_q, lo_q} <= step_res;
            opd_q        <= cur_opd;
            mode_q       <= mode_i;
            run_q        <= 1'b1;
            cnt_q        <= CntW'(1);
        end else if (run_q) begin
            if (done_o) begin
                run_q <= 1'b0;
            end else begin
                {hi_q, lo_q} <= step_res;
                cnt_q        <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu_mc.sv
// Multi-cycle ALU with START/BUSY/DONE handshake; single-cycle ops plus iterative mul/divu.
module seq_alu_mc
    import seq_alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [3:0]       OPRN,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] HI,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO
);

    alu_state_e state_q, state_d;

    logic [WIDTH-1:0] out_q, hi_q;
    logic             zero_q, dz_q, dz_pend_q;

    logic             accept, is_iter_op, is_div, shift_oob;
    logic [WIDTH-1:0] alu_res;
    logic             md_done;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign accept     = START && (state_q == StIdle);
    assign is_div     = (OPRN == ALU_OPRN_DIVU);
    assign is_iter_op = (OPRN == ALU_OPRN_MUL) || is_div;
    // WIDTH is a power of two, so OP2 >= WIDTH exactly when any bit above the shamt field is set.
    assign shift_oob  = |OP2[WIDTH-1:SHAMT_W];

    always_comb begin
        alu_res = '0;
        case (OPRN)
            ALU_OPRN_ADD: alu_res = OP1 + OP2;
            ALU_OPRN_SUB: alu_res = OP1 - OP2;
            ALU_OPRN_SRL: alu_res = shift_oob ? '0 : (OP1 >> OP2[SHAMT_W-1:0]);
            ALU_OPRN_SLL: alu_res = shift_oob ? '0 : (OP1 << OP2[SHAMT_W-1:0]);
            ALU_OPRN_AND: alu_res = OP1 & OP2;
            ALU_OPRN_OR:  alu_res = OP1 | OP2;
            ALU_OPRN_NOR: alu_res = ~(OP1 | OP2);
            ALU_OPRN_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(OP1) < $signed(OP2)};
            default:      alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (START) state_d = is_iter_op ? StIter : StExec;
            StExec:  state_d = StIdle;
            StIter:  if (md_done) state_d = StExec;
            default: state_d = StIdle;
        endcase
    end

    seq_alu_mc_iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_iter_muldiv (
        .clk_i  (CLK),
        .rst_i  (RST),
        .start_i(accept && is_iter_op),
        .mode_i (is_div),
        .op_a_i (OP1),
        .op_b_i (OP2),
        .done_o (md_done),
        .hi_o   (md_hi),
        .lo_o   (md_lo)
    );

    // Results are loaded on the edge that enters StExec, so they appear with DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            out_q     <= '0;
            hi_q      <= '0;
            zero_q    <= 1'b1;
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept && !is_iter_op) begin
                out_q  <= alu_res;
                hi_q   <= '0;
                zero_q <= ~|alu_res;
                dz_q   <= 1'b0;
            end
            if (accept && is_iter_op) begin
                dz_pend_q <= is_div && ~|OP2;
            end
            if ((state_q == StIter) && md_done) begin
                out_q  <= md_lo;
                hi_q   <= md_hi;
                zero_q <= ~|md_lo;
                dz_q   <= dz_pend_q;
            end
        end
    end

    assign OUT      = out_q;
    assign HI       = hi_q;
    assign ZERO     = zero_q;
    assign DIV_ZERO = dz_q;
    assign BUSY     = (state_q != StIdle);
    assign DONE     = (state_q == StExec);

endmodule
